// File: rtl/loop_profiler_pkg.sv
// Shared configuration and types for the short-backward-branch loop profiler.
// Holds subsystem default sizes plus the per-entry state encoding.
package loop_profiler_pkg;

  localparam int NUM_PROFILER_ENTRIES  = 4;
  localparam int PROFILER_ADDR_W       = 32;
  localparam int PROFILER_COUNT_W      = 8;
  localparam int SBB_MAX_OFFSET_BYTES  = 32;
  localparam int TAKEN_COUNT_THRESHOLD = 20;
  localparam int PROFILER_DECAY_PERIOD = 1024;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    COUNTING = 2'd1,
    PENDING  = 2'd2,
    ISSUED   = 2'd3
  } profiler_state_t;

  typedef struct packed {
    profiler_state_t               state;
    logic [PROFILER_ADDR_W-1:0]    branch_pc;
    logic [PROFILER_ADDR_W-1:0]    target;
    logic [PROFILER_COUNT_W-1:0]   count;
  } profiler_entry_t;

endpackage

// File: rtl/loop_profiler_entry.sv
// One profiler table entry: loop addresses, saturating taken counter and lifecycle FSM.
// Exposes next-state values so the top-level arbiter can present a request without extra latency.
module loop_profiler_entry
  import loop_profiler_pkg::*;
#(
  parameter int ADDR_W    = PROFILER_ADDR_W,
  parameter int COUNT_W   = PROFILER_COUNT_W,
  parameter int THRESHOLD = TAKEN_COUNT_THRESHOLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                alloc,
  input  logic [ADDR_W-1:0]   alloc_pc,
  input  logic [ADDR_W-1:0]   alloc_target,
  input  logic                hit,
  input  logic                decay,
  input  logic                rel,
  input  logic                grant,
  output profiler_state_t     state,
  output profiler_state_t     state_next,
  output logic [ADDR_W-1:0]   branch_pc,
  output logic [ADDR_W-1:0]   target,
  output logic [COUNT_W-1:0]  count,
  output logic [COUNT_W-1:0]  count_next
);

  localparam logic [COUNT_W-1:0] THRESH_C  = COUNT_W'(THRESHOLD);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  profiler_state_t    state_reg;
  profiler_state_t    state_next_c;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [ADDR_W-1:0]  target_reg, target_next;
  logic [COUNT_W-1:0] count_reg, count_next_c;
  logic [COUNT_W-1:0] decayed;
  logic [COUNT_W-1:0] bumped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= INVALID;
      pc_reg     <= '0;
      target_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next_c;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      count_reg  <= count_next_c;
    end
  end

  always_comb begin
    state_next_c = state_reg;
    pc_next      = pc_reg;
    target_next  = target_reg;
    count_next_c = count_reg;
    decayed      = decay ? (count_reg >> 1) : count_reg;
    bumped       = (decayed == COUNT_MAX) ? decayed : decayed + COUNT_W'(1);
    if (clear) begin
      state_next_c = INVALID;
      pc_next      = '0;
      target_next  = '0;
      count_next_c = '0;
    end else if (rel) begin
      state_next_c = INVALID;
      count_next_c = '0;
    end else if (alloc) begin
      // A fresh entry starts at 1 regardless of a coincident decay tick.
      state_next_c = (THRESH_C == COUNT_W'(1)) ? PENDING : COUNTING;
      pc_next      = alloc_pc;
      target_next  = alloc_target;
      count_next_c = COUNT_W'(1);
    end else begin
      case (state_reg)
        COUNTING: begin
          if (hit) begin
            count_next_c = bumped;
            if (bumped == THRESH_C) state_next_c = PENDING;
          end else if (decay) begin
            count_next_c = decayed;
            if (decayed == '0) state_next_c = INVALID;
          end
        end
        PENDING: begin
          if (grant) state_next_c = ISSUED;
        end
        default: ;
      endcase
    end
  end

  assign state      = state_reg;
  assign state_next = state_next_c;
  assign branch_pc  = pc_reg;
  assign target     = target_reg;
  assign count      = count_reg;
  assign count_next = count_next_c;

endmodule

// File: rtl/loop_profiler.sv
// Short-backward-branch profiler: qualifies retired branches, tracks candidate loops,
// ages counts, replaces the coldest entry and offers hot loops to the mapping queue.
module loop_profiler
  import loop_profiler_pkg::*;
#(
  parameter int NUM_ENTRIES  = NUM_PROFILER_ENTRIES,
  parameter int ADDR_W       = PROFILER_ADDR_W,
  parameter int MAX_OFFSET   = SBB_MAX_OFFSET_BYTES,
  parameter int COUNT_W      = PROFILER_COUNT_W,
  parameter int THRESHOLD    = TAKEN_COUNT_THRESHOLD,
  parameter int DECAY_PERIOD = PROFILER_DECAY_PERIOD
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               br_valid,
  input  logic [ADDR_W-1:0]                  br_pc,
  input  logic [ADDR_W-1:0]                  br_target,
  input  logic                               br_taken,
  output logic                               req_valid,
  input  logic                               req_ready,
  output logic [ADDR_W-1:0]                  req_branch_pc,
  output logic [ADDR_W-1:0]                  req_target,
  output logic [COUNT_W-1:0]                 req_count,
  input  logic                               rel_valid,
  input  logic [ADDR_W-1:0]                  rel_pc,
  input  logic                               flush,
  output logic                               drop,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES+1);

  profiler_state_t     ent_state      [NUM_ENTRIES];
  profiler_state_t     ent_state_next [NUM_ENTRIES];
  logic [ADDR_W-1:0]   ent_pc         [NUM_ENTRIES];
  logic [ADDR_W-1:0]   ent_target     [NUM_ENTRIES];
  logic [COUNT_W-1:0]  ent_count      [NUM_ENTRIES];
  logic [COUNT_W-1:0]  ent_count_next [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] match_vec, hit_vec, rel_vec, alloc_vec, grant_vec;
  logic [ADDR_W-1:0]      br_offset;
  logic                   qualify, miss, decay;
  logic                   have_free, have_victim, drop_next;
  logic [IDX_W-1:0]       free_idx, victim_idx;
  logic [COUNT_W-1:0]     victim_count;
  logic                   pend_any, rel_presented, handshake;
  logic [IDX_W-1:0]       pend_idx;
  logic [OCC_W-1:0]       occ_next;

  logic                   req_valid_reg;
  logic [IDX_W-1:0]       req_idx_reg;
  logic [ADDR_W-1:0]      req_pc_reg, req_target_reg;
  logic [COUNT_W-1:0]     req_count_reg;
  logic                   drop_reg;
  logic [OCC_W-1:0]       occ_reg;

  assign br_offset = br_pc - br_target;
  assign qualify   = br_valid & br_taken & (br_target < br_pc) &
                     (br_offset <= ADDR_W'(MAX_OFFSET));

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign match_vec[gi] = (ent_state[gi] != INVALID) && (ent_pc[gi] == br_pc);
      assign hit_vec[gi]   = qualify & match_vec[gi];
      assign rel_vec[gi]   = rel_valid && (ent_state[gi] != INVALID) && (ent_pc[gi] == rel_pc);

      loop_profiler_entry #(
        .ADDR_W    (ADDR_W),
        .COUNT_W   (COUNT_W),
        .THRESHOLD (THRESHOLD)
      ) u_entry (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (flush),
        .alloc        (alloc_vec[gi]),
        .alloc_pc     (br_pc),
        .alloc_target (br_target),
        .hit          (hit_vec[gi]),
        .decay        (decay),
        .rel          (rel_vec[gi]),
        .grant        (grant_vec[gi]),
        .state        (ent_state[gi]),
        .state_next   (ent_state_next[gi]),
        .branch_pc    (ent_pc[gi]),
        .target       (ent_target[gi]),
        .count        (ent_count[gi]),
        .count_next   (ent_count_next[gi])
      );
    end

    if (DECAY_PERIOD > 0) begin : g_decay
      localparam int TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
      localparam logic [TW-1:0] LAST = TW'(DECAY_PERIOD - 1);
      logic [TW-1:0] timer_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 timer_reg <= '0;
        else if (flush)             timer_reg <= '0;
        else if (timer_reg == LAST) timer_reg <= '0;
        else                        timer_reg <= timer_reg + TW'(1);
      end
      assign decay = (timer_reg == LAST);
    end else begin : g_no_decay
      assign decay = 1'b0;
    end
  endgenerate

  // Victim choice: first free slot, else the coldest COUNTING entry (lowest index on ties).
  always_comb begin
    have_free    = 1'b0;
    free_idx     = '0;
    have_victim  = 1'b0;
    victim_idx   = '0;
    victim_count = '1;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_state[i] == INVALID) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_state[i] == COUNTING && (!have_victim || ent_count[i] < victim_count)) begin
        have_victim  = 1'b1;
        victim_idx   = IDX_W'(i);
        victim_count = ent_count[i];
      end
    end
    miss      = qualify & ~(|match_vec);
    alloc_vec = '0;
    if (miss) begin
      if (have_free)        alloc_vec[free_idx]   = 1'b1;
      else if (have_victim) alloc_vec[victim_idx] = 1'b1;
    end
    drop_next = miss & ~have_free & ~have_victim;
  end

  always_comb begin
    rel_presented = req_valid_reg & rel_vec[req_idx_reg];
    handshake     = req_valid_reg & req_ready & ~rel_presented;
    grant_vec     = '0;
    if (handshake) grant_vec[req_idx_reg] = 1'b1;
  end

  // Looks at post-update entry state so a newly promoted loop is offered on the next cycle.
  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    occ_next = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_state_next[i] == PENDING) begin
        pend_any = 1'b1;
        pend_idx = IDX_W'(i);
      end
      if (ent_state_next[i] != INVALID) occ_next = occ_next + OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_reg  <= 1'b0;
      req_idx_reg    <= '0;
      req_pc_reg     <= '0;
      req_target_reg <= '0;
      req_count_reg  <= '0;
      drop_reg       <= 1'b0;
      occ_reg        <= '0;
    end else if (flush) begin
      req_valid_reg  <= 1'b0;
      req_idx_reg    <= '0;
      req_pc_reg     <= '0;
      req_target_reg <= '0;
      req_count_reg  <= '0;
      drop_reg       <= 1'b0;
      occ_reg        <= '0;
    end else begin
      drop_reg <= drop_next;
      occ_reg  <= occ_next;
      if (!req_valid_reg || handshake) begin
        req_valid_reg <= pend_any;
        if (pend_any) begin
          req_idx_reg    <= pend_idx;
          req_pc_reg     <= alloc_vec[pend_idx] ? br_pc     : ent_pc[pend_idx];
          req_target_reg <= alloc_vec[pend_idx] ? br_target : ent_target[pend_idx];
          req_count_reg  <= ent_count_next[pend_idx];
        end
      end else if (rel_presented) begin
        req_valid_reg <= 1'b0;
      end
    end
  end

  assign req_valid     = req_valid_reg;
  assign req_branch_pc = req_pc_reg;
  assign req_target    = req_target_reg;
  assign req_count     = req_count_reg;
  assign drop          = drop_reg;
  assign occupancy     = occ_reg;

endmodule

// File: tb/tb_loop_profiler.sv
// Directed bench for loop_profiler: promotion, qualification, replacement, arbitration,
// decay, async reset and flush; a second instance uses a short decay period.
module tb_loop_profiler;
  import loop_profiler_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        br_valid, br_taken, req_ready, rel_valid, flush;
  logic [31:0] br_pc, br_target, rel_pc;

  logic        req_valid, drop;
  logic [31:0] req_branch_pc, req_target;
  logic [7:0]  req_count;
  logic [2:0]  occupancy;

  logic        req_valid_d, drop_d;
  logic [31:0] req_branch_pc_d, req_target_d;
  logic [7:0]  req_count_d;
  logic [2:0]  occupancy_d;

  int checks = 0;
  int errors = 0;

  loop_profiler dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_pc(br_pc), .br_target(br_target),
    .br_taken(br_taken), .req_valid(req_valid), .req_ready(req_ready),
    .req_branch_pc(req_branch_pc), .req_target(req_target), .req_count(req_count),
    .rel_valid(rel_valid), .rel_pc(rel_pc), .flush(flush), .drop(drop), .occupancy(occupancy)
  );

  loop_profiler #(.DECAY_PERIOD(16)) dut_d (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_pc(br_pc), .br_target(br_target),
    .br_taken(br_taken), .req_valid(req_valid_d), .req_ready(req_ready),
    .req_branch_pc(req_branch_pc_d), .req_target(req_target_d), .req_count(req_count_d),
    .rel_valid(rel_valid), .rel_pc(rel_pc), .flush(flush), .drop(drop_d), .occupancy(occupancy_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_pc = '0; br_target = '0;
    req_ready = 1'b0; rel_valid = 1'b0; rel_pc = '0; flush = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic send_br(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    br_valid = 1'b1; br_pc = pc; br_target = tgt; br_taken = taken;
    step();
    br_valid = 1'b0; br_taken = 1'b0;
  endtask

  task automatic send_n(input logic [31:0] pc, input logic [31:0] tgt, input int n);
    repeat (n) send_br(pc, tgt, 1'b1);
  endtask

  initial begin
    // Reset state and basic promotion.
    do_reset();
    check_eq("rst_req_valid", req_valid, 0);
    check_eq("rst_req_pc", req_branch_pc, 0);
    check_eq("rst_req_target", req_target, 0);
    check_eq("rst_req_count", req_count, 0);
    check_eq("rst_drop", drop, 0);
    check_eq("rst_occupancy", occupancy, 0);
    send_n(32'h100, 32'hF0, 19);
    check_eq("t1_no_req_at_19", req_valid, 0);
    check_eq("t1_count_19", dut.g_entry[0].u_entry.count_reg, 19);
    send_br(32'h100, 32'hF0, 1'b1);
    check_eq("t1_req_valid", req_valid, 1);
    check_eq("t1_req_pc", req_branch_pc, 32'h100);
    check_eq("t1_req_target", req_target, 32'hF0);
    check_eq("t1_req_count", req_count, 20);
    check_eq("t1_occupancy", occupancy, 1);

    // Qualification boundaries.
    do_reset();
    send_br(32'h100, 32'h80, 1'b1);
    check_eq("t2_offset128", occupancy, 0);
    send_br(32'h100, 32'h120, 1'b1);
    check_eq("t2_forward", occupancy, 0);
    send_br(32'h100, 32'hF0, 1'b0);
    check_eq("t2_not_taken", occupancy, 0);
    send_br(32'h100, 32'h100, 1'b1);
    check_eq("t2_self", occupancy, 0);
    send_br(32'h100, 32'hDF, 1'b1);
    check_eq("t2_offset33", occupancy, 0);
    check_eq("t2_no_req", req_valid, 0);
    send_br(32'h100, 32'hE0, 1'b1);
    check_eq("t2_offset32", occupancy, 1);

    // Replacement, drop, arbitration and release.
    do_reset();
    send_n(32'h100, 32'hF8, 5);
    send_n(32'h200, 32'h1F8, 2);
    send_n(32'h300, 32'h2F8, 2);
    send_n(32'h400, 32'h3F8, 7);
    check_eq("t3_entry3_count", dut.g_entry[3].u_entry.count_reg, 7);
    send_br(32'h500, 32'h4F8, 1'b1);
    check_eq("t3_victim_pc", dut.g_entry[1].u_entry.pc_reg, 32'h500);
    check_eq("t3_victim_count", dut.g_entry[1].u_entry.count_reg, 1);
    check_eq("t3_entry2_kept", dut.g_entry[2].u_entry.count_reg, 2);
    check_eq("t3_occupancy", occupancy, 4);
    send_n(32'h100, 32'hF8, 15);
    send_n(32'h500, 32'h4F8, 19);
    send_n(32'h300, 32'h2F8, 18);
    send_n(32'h400, 32'h3F8, 13);
    check_eq("t3_req_valid", req_valid, 1);
    check_eq("t3_req_pc", req_branch_pc, 32'h100);
    check_eq("t3_req_target", req_target, 32'hF8);
    check_eq("t3_req_count", req_count, 20);
    send_br(32'h100, 32'hF8, 1'b1);
    check_eq("t3_pending_hit_count", dut.g_entry[0].u_entry.count_reg, 20);
    check_eq("t3_no_drop_on_hit", drop, 0);
    send_br(32'h600, 32'h5F8, 1'b1);
    check_eq("t3_drop", drop, 1);
    check_eq("t3_drop_occ", occupancy, 4);
    step();
    check_eq("t3_drop_once", drop, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq($sformatf("t4_hold_pc_%0d", i), req_branch_pc, 32'h100);
    end
    check_eq("t4_hold_valid", req_valid, 1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    check_eq("t4_next_valid", req_valid, 1);
    check_eq("t4_next_pc", req_branch_pc, 32'h500);
    check_eq("t4_next_target", req_target, 32'h4F8);
    check_eq("t4_entry0_issued", dut.g_entry[0].u_entry.state_reg, ISSUED);
    rel_valid = 1'b1; rel_pc = 32'h100;
    step();
    rel_valid = 1'b0;
    check_eq("t4_release_occ", occupancy, 3);
    check_eq("t4_still_presenting", req_branch_pc, 32'h500);

    // Asynchronous reset while a request is outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_req_valid", req_valid, 0);
    check_eq("t5_async_req_pc", req_branch_pc, 0);
    check_eq("t5_async_req_count", req_count, 0);
    check_eq("t5_async_occ", occupancy, 0);

    // Flush overrides a same-cycle hit and release.
    do_reset();
    send_n(32'h100, 32'hF0, 3);
    send_n(32'h200, 32'h1F0, 2);
    check_eq("t6_pre_occ", occupancy, 2);
    flush = 1'b1; rel_valid = 1'b1; rel_pc = 32'h200;
    send_br(32'h100, 32'hF0, 1'b1);
    flush = 1'b0; rel_valid = 1'b0;
    check_eq("t6_flush_occ", occupancy, 0);
    check_eq("t6_flush_req", req_valid, 0);
    send_br(32'h100, 32'hF0, 1'b1);
    check_eq("t6_realloc_count", dut.g_entry[0].u_entry.count_reg, 1);

    // Decay on the 16-cycle instance.
    do_reset();
    send_n(32'h200, 32'h1F0, 9);
    check_eq("t7_count9", dut_d.g_entry[0].u_entry.count_reg, 9);
    idle(7);
    check_eq("t7_decay_4", dut_d.g_entry[0].u_entry.count_reg, 4);
    idle(16);
    check_eq("t7_decay_2", dut_d.g_entry[0].u_entry.count_reg, 2);
    idle(16);
    check_eq("t7_decay_1", dut_d.g_entry[0].u_entry.count_reg, 1);
    check_eq("t7_occ_1", occupancy_d, 1);
    idle(16);
    check_eq("t7_decay_invalid", dut_d.g_entry[0].u_entry.state_reg, INVALID);
    check_eq("t7_occ_0", occupancy_d, 0);
    check_eq("t7_no_req", req_valid_d, 0);

    do_reset();
    send_n(32'h200, 32'h1F0, 9);
    idle(6);
    send_br(32'h200, 32'h1F0, 1'b1);
    check_eq("t8_decay_hit", dut_d.g_entry[0].u_entry.count_reg, 5);
    check_eq("t8_decay_hit_state", dut_d.g_entry[0].u_entry.state_reg, COUNTING);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_profiler.md
Name: loop_profiler

Overview:
- Parametrised short-backward-branch (SBB) profiler for the RCA subsystem.
- Watches retired branches and tracks up to NUM_ENTRIES candidate loops with saturating taken counters.
- When a loop crosses the taken-count threshold, it raises a valid/ready request to the PR/mapping queue.
- Beyond a fixed 4-entry profiler, it adds:
  - configurable entry count, counter width and offset window;
  - periodic count decay (aging);
  - lowest-count victim replacement;
  - explicit release of issued loops.

Parameters:
NUM_ENTRIES, 4, number of tracked loop entries (>=2)
ADDR_W, 32, PC/target width in bits
MAX_OFFSET, 32, largest qualifying backward distance in bytes (pc - target)
COUNT_W, 8, taken counter width; counter saturates at 2^COUNT_W-1
THRESHOLD, 20, taken count that promotes an entry to PENDING (1..2^COUNT_W-1)
DECAY_PERIOD, 1024, cycles between decay events; 0 disables decay

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
br_valid  in  1  retired branch report this cycle
br_pc  in  ADDR_W  branch instruction address
br_target  in  ADDR_W  branch target address
br_taken  in  1  branch was taken
req_valid  out  1  promoted loop awaiting mapping
req_ready  in  1  mapping queue accepts request
req_branch_pc  out  ADDR_W  branch PC of requested loop (loop end)
req_target  out  ADDR_W  loop start address
req_count  out  COUNT_W  counter value at request time
rel_valid  in  1  release a loop (mapping done or aborted)
rel_pc  in  ADDR_W  branch PC to release
flush  in  1  synchronous clear of all entries
drop  out  1  one-cycle pulse: qualifying miss with no replaceable entry
occupancy  out  $clog2(NUM_ENTRIES+1)  number of non-INVALID entries

Behaviour:
- Reset (rst_n low, async):
  - all entries INVALID, counts 0, decay timer 0;
  - req_valid=0, req_branch_pc=0, req_target=0, req_count=0, drop=0, occupancy=0.
- SBB qualify (combinational): br_valid & br_taken & (br_target < br_pc) & ((br_pc - br_target) <= MAX_OFFSET). Subtraction is unsigned, ADDR_W wide.
- Per-entry state:
  - INVALID -> COUNTING on allocation, count=1.
  - COUNTING -> PENDING when the incremented count == THRESHOLD.
  - PENDING -> ISSUED on req handshake.
  - ISSUED -> INVALID on rel_valid with rel_pc == entry pc.
  - rel_valid on a COUNTING or PENDING entry also invalidates it.
- Lookup is by br_pc across all valid entries; at most one entry matches.
  - Hit in COUNTING: count+1, saturating.
  - Hit in PENDING/ISSUED: no change.
- Miss on a qualifying branch:
  - allocate the lowest-index INVALID entry;
  - otherwise replace the COUNTING entry with the lowest count, ties to the lowest index;
  - if none is replaceable (all PENDING/ISSUED), discard and drop=1 next cycle.
- Latency: table update at the clock edge ending the br_valid cycle; req_valid can assert the following cycle.
- Request arbiter:
  - lowest-index PENDING entry drives req_*, registered;
  - once req_valid=1, req_* are held stable until req_valid & req_ready;
  - after a handshake, the next PENDING entry may present the cycle after.
- Decay:
  - when DECAY_PERIOD>0, the timer counts 0..DECAY_PERIOD-1; on wrap, every COUNTING count >>= 1;
  - a COUNTING entry reaching 0 becomes INVALID;
  - PENDING/ISSUED counts are not decayed.
- Simultaneous events on the same entry:
  - decay + hit: count = (count>>1)+1, then threshold check;
  - rel_valid + hit: release wins;
  - release of the entry currently presented with req_valid=1: release wins, req_valid drops next cycle, no handshake recorded;
  - decay + allocation: allocated entry starts at 1, undecayed.
- flush: same effect as reset on the next edge, including timer and req_valid, overriding all other events.
- occupancy is registered and reflects post-update state.
- Asserting rst_n low mid-handshake aborts the request; no partial state survives.

Decomposition:
- Shared package rca_config gains:
  - NUM_PROFILER_ENTRIES, PROFILER_COUNT_W, SBB_MAX_OFFSET_BYTES, TAKEN_COUNT_THRESHOLD, PROFILER_DECAY_PERIOD;
  - typedef enum profiler_state_t {INVALID, COUNTING, PENDING, ISSUED};
  - typedef struct profiler_entry_t {state, branch_pc, target, count}.
- Sub-module profiler_entry: one entry's registers and state machine. Inputs: hit, alloc, decay, release, grant. The top level instantiates NUM_ENTRIES copies and holds qualify, victim select, arbiter and decay timer.

Test Plan:
- Reset then 20 taken branches pc=0x100 target=0xF0 -> count reaches 20, req_valid=1 one cycle after the 20th, req_branch_pc=0x100, req_target=0xF0, req_count=20.
- Non-qualifying branches (pc=0x100 target=0x80, offset 128 > 32; target > pc; not taken) -> occupancy stays 0, no req_valid.
- Fill 4 entries with counts 5,2,2,7, then new SBB pc=0x500 -> entry 1 replaced, count=1, occupancy=4. With all 4 PENDING/ISSUED, new SBB -> drop pulses once.
- req_ready held 0 for 10 cycles while 2 entries PENDING -> req_* stable. req_ready=1 -> entry 0 ISSUED, entry 1 presented the next cycle. rel_pc of entry 0 -> occupancy decrements.
- DECAY_PERIOD=16, entry count 9, no branches -> count 4 after 16 cycles, then 2, 1, then INVALID. A hit in the decay cycle at count 9 -> 5.
- rst_n low mid-request with req_valid=1 -> all outputs 0 asynchronously. flush with hit and release in the same cycle -> table empty.
